fwd_source_pipe: RTL

FWD_SOURCE_PIPE -- requirements
Module: fwd_source_pipe

---
 rtl/fwd_source_pipe_pkg.sv | 7 +
 rtl/dest_stage_reg.sv | 34 +++
 rtl/fwd_source_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/fwd_source_pipe_pkg.sv
// fwd_source_pipe_pkg: shared types and defaults for the forwarding-source pipeline
package fwd_source_pipe_pkg;
    typedef enum logic {RUN, MEM_WAIT} state_e;
    localparam int REG_ADDR_W      = 5;
    localparam int XLEN_DEF        = 32;
    localparam int MEM_TIMEOUT_DEF = 15;
endpackage

// File: rtl/dest_stage_reg.sv
// dest_stage_reg: one pipeline destination register (rd, regwrite, memread, data) with hold and bubble
module dest_stage_reg
    import fwd_source_pipe_pkg::*;
#(
    parameter int W = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_i,
    input  logic                  bubble_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  regwrite_i,
    input  logic                  memread_i,
    input  logic [W-1:0]          data_i,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  regwrite_o,
    output logic                  memread_o,
    output logic [W-1:0]          data_o
);
    // Reset and bubble clear the entry; hold keeps it; otherwise capture the upstream stage
    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            rd_o       <= '0;
            regwrite_o <= 1'b0;
            memread_o  <= 1'b0;
            data_o     <= '0;
        end else if (!hold_i) begin
            rd_o       <= rd_i;
            regwrite_o <= regwrite_i;
            memread_o  <= memread_i;
            data_o     <= data_i;
        end
    end
endmodule

// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe: EX/MEM and MEM/WB forward sources with load-use detection and memory-wait handling
module fwd_source_pipe
    import fwd_source_pipe_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_regwrite,
    input  logic                  id_ex_memread,
    input  logic                  id_ex_valid,
    input  logic [XLEN-1:0]       ex_result,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_uses_rs2,
    input  logic                  mem_ready,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic                  ex_mem_regwrite,
    output logic [XLEN-1:0]       ex_mem_data,
    output logic [REG_ADDR_W-1:0] mem_wb_rd,
    output logic                  mem_wb_regwrite,
    output logic [XLEN-1:0]       mem_wb_data,
    output logic                  load_use_stall,
    output logic                  mem_stall,
    output logic                  mem_timeout
);
    localparam logic [3:0] TMO = 4'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       tmo_q;
    logic       ex_mem_memread;
    logic       wb_memread_unused;

    assign mem_stall   = ex_mem_memread && !mem_ready;
    assign mem_timeout = tmo_q;

    // Hazard flags and next wait state; the counter only advances while already in MEM_WAIT
    always_comb begin
        load_use_stall = id_ex_valid && id_ex_memread && id_ex_regwrite && (id_ex_rd != '0) &&
                         ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
        state_d = mem_stall ? MEM_WAIT : RUN;
        cnt_d   = !mem_stall ? 4'd0 :
                  (state_q == MEM_WAIT && cnt_q != TMO) ? cnt_q + 4'd1 : cnt_q;
    end

    // Wait FSM with saturating counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_q || (cnt_d == TMO);
        end
    end

    dest_stage_reg #(.W(XLEN)) u_ex_mem (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (mem_stall),
        .bubble_i   (1'b0),
        .rd_i       (id_ex_rd),
        .regwrite_i (id_ex_regwrite && id_ex_valid && (id_ex_rd != '0)),
        .memread_i  (id_ex_memread && id_ex_valid),
        .data_i     (ex_result),
        .rd_o       (ex_mem_rd),
        .regwrite_o (ex_mem_regwrite),
        .memread_o  (ex_mem_memread),
        .data_o     (ex_mem_data)
    );

    dest_stage_reg #(.W(XLEN)) u_mem_wb (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (1'b0),
        .bubble_i   (mem_stall),
        .rd_i       (ex_mem_rd),
        .regwrite_i (ex_mem_regwrite),
        .memread_i  (1'b0),
        .data_i     (ex_mem_memread ? mem_rdata : ex_mem_data),
        .rd_o       (mem_wb_rd),
        .regwrite_o (mem_wb_regwrite),
        .memread_o  (wb_memread_unused),
        .data_o     (mem_wb_data)
    );
endmodule
